bram_load_ctrl: RTL and testbench

BRAM_LOAD_CTRL -- requirements
Module: bram_load_ctrl

---
 rtl/bram_load_ctrl_if.sv | 64 ++++++
 rtl/bram_load_ctrl.sv | 148 ++++++++++++++
 tb/tb_bram_load_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_load_ctrl_if.sv
// rtl/bram_load_ctrl_if.sv - UART-to-BRAM load port bundle
//
// Purpose: groups the byte-stream input, load-window control and BRAM write
// port of bram_load_ctrl into one interface.
//
// Signals:
//   rx_ready       one-cycle strobe, rx_data valid
//   rx_data        received UART byte
//   flag_bram      load window open (held by the BRAM-select FSM)
//   sel_bram       target BRAM, 0 = A, 1 = B
//   bram_we_a      write enable, BRAM A
//   bram_we_b      write enable, BRAM B
//   bram_addr      write address
//   bram_din       write data, one vector element
//   flag_end_write one-cycle pulse, full vector written
//   busy_load      high whenever the loader is not idle
//
// Modports:
//   master  the side that supplies bytes and the window (UART/select FSM)
//   slave   the loader itself

interface bram_load_ctrl_if #(
  parameter int ELEM_BYTES = 2,
  parameter int ADDR_WIDTH = 10
);

  logic                    rx_ready;
  logic [7:0]              rx_data;
  logic                    flag_bram;
  logic                    sel_bram;
  logic                    bram_we_a;
  logic                    bram_we_b;
  logic [ADDR_WIDTH-1:0]   bram_addr;
  logic [8*ELEM_BYTES-1:0] bram_din;
  logic                    flag_end_write;
  logic                    busy_load;

  modport master (
    output rx_ready,
    output rx_data,
    output flag_bram,
    output sel_bram,
    input  bram_we_a,
    input  bram_we_b,
    input  bram_addr,
    input  bram_din,
    input  flag_end_write,
    input  busy_load
  );

  modport slave (
    input  rx_ready,
    input  rx_data,
    input  flag_bram,
    input  sel_bram,
    output bram_we_a,
    output bram_we_b,
    output bram_addr,
    output bram_din,
    output flag_end_write,
    output busy_load
  );

endinterface

// File: rtl/bram_load_ctrl.sv
// rtl/bram_load_ctrl.sv - assembles UART bytes into vector elements and writes them to BRAM A or B
//
// Purpose: while the load window (flag_bram) is open, collects ELEM_BYTES
// received bytes per element (little-endian), writes each complete element
// to the selected BRAM at consecutive addresses, and pulses flag_end_write
// once VECTOR_LEN elements have been written. The window must close before
// another load can start.
//
// Parameters:
//   ELEM_BYTES  UART bytes per vector element (1..4)
//   VECTOR_LEN  elements per vector load (<= 2**ADDR_WIDTH)
//   ADDR_WIDTH  BRAM address width
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-high reset
//   bus    slave side of bram_load_ctrl_if (byte input, window control,
//          BRAM write port, status flags)

module bram_load_ctrl #(
  parameter int ELEM_BYTES = 2,
  parameter int VECTOR_LEN = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  bram_load_ctrl_if.slave   bus
);

  localparam int DW   = 8 * ELEM_BYTES;
  localparam int BC_W = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;

  localparam logic [BC_W-1:0]     LAST_BYTE = BC_W'(ELEM_BYTES - 1);
  // Element counter value once the whole vector has been captured. The
  // counter is one bit wider than the address so a full 2**ADDR_WIDTH load
  // does not wrap back to zero.
  localparam logic [ADDR_WIDTH:0] VEC_CNT   = (ADDR_WIDTH + 1)'(VECTOR_LEN);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]            state;
  logic                  tgt;
  logic [BC_W-1:0]       byte_cnt;
  logic [ADDR_WIDTH:0]   elem_cnt;
  logic [DW-1:0]         asm_word;

  logic [DW+7:0]         shift_cat;
  logic [DW-1:0]         word_next;
  logic                  vec_full;
  logic                  take_byte;
  logic                  elem_done;

  // New bytes enter at the top and older bytes move down, so after
  // ELEM_BYTES shifts the first byte received sits in bits [7:0].
  always_comb begin
    shift_cat = {bus.rx_data, asm_word};
    word_next = shift_cat[DW+7:8];
  end

  // Once the last element is captured, elem_cnt equals VEC_CNT and further
  // bytes are ignored, including one arriving while that last write is on
  // the bus. An open window is required, so an abort always beats a byte.
  always_comb begin
    vec_full  = (elem_cnt == VEC_CNT);
    take_byte = (state == S_LOAD) && bus.flag_bram && bus.rx_ready && !vec_full;
    elem_done = take_byte && (byte_cnt == LAST_BYTE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      tgt                <= 1'b0;
      byte_cnt           <= '0;
      elem_cnt           <= '0;
      asm_word           <= '0;
      bus.bram_we_a      <= 1'b0;
      bus.bram_we_b      <= 1'b0;
      bus.bram_addr      <= '0;
      bus.bram_din       <= '0;
      bus.flag_end_write <= 1'b0;
      bus.busy_load      <= 1'b0;
    end else begin
      // Strobes default low; address and data hold between writes.
      bus.bram_we_a      <= 1'b0;
      bus.bram_we_b      <= 1'b0;
      bus.flag_end_write <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.flag_bram) begin
            tgt           <= bus.sel_bram;
            byte_cnt      <= '0;
            elem_cnt      <= '0;
            asm_word      <= '0;
            state         <= S_LOAD;
            bus.busy_load <= 1'b1;
          end
        end

        S_LOAD: begin
          if (!bus.flag_bram) begin
            // Abort: the partial element is simply left in asm_word and
            // cleared on the next start.
            state         <= S_IDLE;
            bus.busy_load <= 1'b0;
          end else if (vec_full) begin
            // The final write was presented in the previous cycle.
            state              <= S_DONE;
            bus.flag_end_write <= 1'b1;
          end else if (elem_done) begin
            bus.bram_we_a <= ~tgt;
            bus.bram_we_b <= tgt;
            bus.bram_addr <= elem_cnt[ADDR_WIDTH-1:0];
            bus.bram_din  <= word_next;
            asm_word      <= word_next;
            byte_cnt      <= '0;
            elem_cnt      <= elem_cnt + 1'b1;
          end else if (take_byte) begin
            asm_word <= word_next;
            byte_cnt <= byte_cnt + BC_W'(1);
          end
        end

        S_DONE: begin
          state <= S_RELEASE;
        end

        S_RELEASE: begin
          // Wait for the window to close so a held flag_bram cannot start
          // a second load.
          if (!bus.flag_bram) begin
            state         <= S_IDLE;
            bus.busy_load <= 1'b0;
          end
        end

        default: begin
          state         <= S_IDLE;
          bus.busy_load <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_load_ctrl.sv
// tb/tb_bram_load_ctrl.sv - scoreboard bench for bram_load_ctrl

module tb_bram_load_ctrl;

  localparam int EB  = 2;
  localparam int VL  = 4;
  localparam int AW  = 2;

  typedef struct {
    logic        b;
    logic [1:0]  a;
    logic [15:0] d;
  } wr_t;

  logic clk;
  logic reset;

  bram_load_ctrl_if #(.ELEM_BYTES(EB), .ADDR_WIDTH(AW)) bus ();

  bram_load_ctrl #(
    .ELEM_BYTES(EB),
    .VECTOR_LEN(VL),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_pass  = 0;
  int  n_total = 0;
  int  end_cnt = 0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic b, input logic [1:0] a, input logic [15:0] d);
    wr_t e;
    e.b = b; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented write is popped against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.flag_end_write) end_cnt++;
      if (bus.bram_we_a || bus.bram_we_b) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {14'd0, bus.bram_we_a, bus.bram_we_b, bus.bram_din}, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_we", {30'd0, bus.bram_we_a, bus.bram_we_b}, e.b ? 32'd1 : 32'd2);
          check("write_addr", {30'd0, bus.bram_addr}, {30'd0, e.a});
          check("write_din", {16'd0, bus.bram_din}, {16'd0, e.d});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_win(input logic sel);
    bus.flag_bram = 1'b1;
    bus.sel_bram  = sel;
    tick();
  endtask

  task automatic send(input logic [7:0] b, input int gap, input logic toggle);
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_ready = 1'b0;
    if (toggle) bus.sel_bram = ~bus.sel_bram;
    repeat (gap) tick();
  endtask

  task automatic close_win();
    bus.flag_bram = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"}, {30'd0, bus.bram_we_a, bus.bram_we_b}, 32'd0);
    check({tag, "_addr"}, {30'd0, bus.bram_addr}, 32'd0);
    check({tag, "_din"}, {16'd0, bus.bram_din}, 32'd0);
    check({tag, "_end"}, {31'd0, bus.flag_end_write}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy_load}, 32'd0);
  endtask

  int exp_end;

  initial begin
    exp_end      = 0;
    reset        = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.flag_bram = 1'b0;
    bus.sel_bram = 1'b0;
    #1;
    check_outputs_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Full load to A, one idle cycle between bytes
    push(0, 2'd0, 16'h0201); push(0, 2'd1, 16'h0403);
    push(0, 2'd2, 16'h0605); push(0, 2'd3, 16'h0807);
    exp_end++;
    open_win(1'b0);
    for (int i = 1; i <= 8; i++) send(8'(i), 1, 1'b0);
    repeat (3) tick();
    check("t1_end_cnt", end_cnt, exp_end);
    check("t1_busy_release", {31'd0, bus.busy_load}, 32'd1);
    close_win();
    check("t1_busy_idle", {31'd0, bus.busy_load}, 32'd0);

    // Back-to-back bytes to B, then hold the window with extra bytes
    push(1, 2'd0, 16'h1211); push(1, 2'd1, 16'h1413);
    push(1, 2'd2, 16'h1615); push(1, 2'd3, 16'h1817);
    exp_end++;
    open_win(1'b1);
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 0, 1'b0);
    repeat (3) tick();
    check("t2_end_cnt", end_cnt, exp_end);
    for (int i = 0; i < 10; i++) send(8'hE0 + 8'(i), 0, 1'b0);
    check("t2_busy_held", {31'd0, bus.busy_load}, 32'd1);
    check("t2_end_held", end_cnt, exp_end);
    close_win();
    check("t2_busy_idle", {31'd0, bus.busy_load}, 32'd0);

    // Abort after three bytes; fourth byte coincides with the window drop
    push(0, 2'd0, 16'h0201);
    open_win(1'b0);
    send(8'h01, 1, 1'b0);
    send(8'h02, 1, 1'b0);
    send(8'h03, 1, 1'b0);
    bus.rx_ready  = 1'b1;
    bus.rx_data   = 8'h04;
    bus.flag_bram = 1'b0;
    tick();
    bus.rx_ready = 1'b0;
    check("t3_busy_after_abort", {31'd0, bus.busy_load}, 32'd0);
    repeat (4) tick();
    check("t3_end_cnt", end_cnt, exp_end);

    // Asynchronous reset between edges in the middle of a load
    push(0, 2'd0, 16'h3231);
    open_win(1'b0);
    send(8'h31, 1, 1'b0);
    send(8'h32, 1, 1'b0);
    send(8'h33, 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("t4_async");
    bus.flag_bram = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("t4_idle_wait", {31'd0, bus.busy_load}, 32'd0);
    push(1, 2'd0, 16'hA2A1); push(1, 2'd1, 16'hA4A3);
    push(1, 2'd2, 16'hA6A5); push(1, 2'd3, 16'hA8A7);
    exp_end++;
    open_win(1'b1);
    for (int i = 0; i < 8; i++) send(8'hA1 + 8'(i), 1, 1'b0);
    repeat (3) tick();
    check("t4_end_cnt", end_cnt, exp_end);
    close_win();

    // sel_bram toggles after every byte; target stays B
    push(1, 2'd0, 16'h2221); push(1, 2'd1, 16'h2423);
    push(1, 2'd2, 16'h2625); push(1, 2'd3, 16'h2827);
    exp_end++;
    open_win(1'b1);
    for (int i = 0; i < 8; i++) send(8'h21 + 8'(i), 1, 1'b1);
    repeat (3) tick();
    check("t5_end_cnt", end_cnt, exp_end);
    close_win();

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, bus.busy_load}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
